// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared matrix geometry, qualifier FSM state type and one-hot
//            helpers for the ball position reader.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int MATRIX_DIM = 8;
  localparam int COORD_W    = 3;

  // TRACK: counting identical samples of the candidate.
  // WAIT : candidate already handled, idle until the sample changes.
  typedef enum logic [0:0] {
    ST_TRACK = 1'b0,
    ST_WAIT  = 1'b1
  } qual_state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [MATRIX_DIM-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Index of the set bit; only meaningful when is_onehot(v) holds.
  function automatic logic [COORD_W-1:0] onehot_index(input logic [MATRIX_DIM-1:0] v);
    logic [COORD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MATRIX_DIM; i++) begin
      if (v[i]) idx = COORD_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ball_decode.sv
// ============================================================================
// Module   : ball_decode
// Purpose  : Combinational decode of a matrix drive pattern into ball
//            position. Legal patterns are "off" (both drives zero) or
//            "lit" (one column high, one row low); all others are illegal.
// Ports    : i_sx    column drive, active-high
//            i_sy    row drive, active-low
//            o_legal pattern is off or lit
//            o_on    pattern is lit
//            o_x     column index (0 unless lit)
//            o_y     row index (0 unless lit)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ball_decode
  import pong_pkg::*;
(
  input  logic [MATRIX_DIM-1:0] i_sx,
  input  logic [MATRIX_DIM-1:0] i_sy,
  output logic                  o_legal,
  output logic                  o_on,
  output logic [COORD_W-1:0]    o_x,
  output logic [COORD_W-1:0]    o_y
);

  logic w_off;
  logic w_lit;

  assign w_off   = (i_sx == '0) && (i_sy == '0);
  // Rows are active-low, so invert before the one-hot test.
  assign w_lit   = is_onehot(i_sx) && is_onehot(~i_sy);
  assign o_legal = w_off || w_lit;
  assign o_on    = w_lit;
  assign o_x     = w_lit ? onehot_index(i_sx)  : '0;
  assign o_y     = w_lit ? onehot_index(~i_sy) : '0;

endmodule

`default_nettype wire

// File: rtl/ball_read.sv
// ============================================================================
// Module   : ball_read
// Purpose  : Samples the LED matrix drive {Sx,Sy}, qualifies a pattern once
//            it has been stable for STABLE_CYCLES samples, and reports each
//            new legal position through a valid/ready output register.
//            Illegal qualified patterns and dropped events raise sticky
//            error flags cleared by err_clr.
// Macro    : BALL_READ_SYNC_EN - two-flop synchronizer on the inputs
//            (otherwise a single register stage).
// Ports    : clk, rst_n (async, active-low)
//            Sx, Sy          matrix drive inputs
//            out_x/out_y/out_on, out_valid, out_ready  event handshake
//            err_illegal, err_overrun, err_clr          sticky error flags
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ball_read
  import pong_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MATRIX_DIM-1:0] Sx,
  input  logic [MATRIX_DIM-1:0] Sy,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  out_on,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_illegal,
  output logic                  err_overrun,
  input  logic                  err_clr
);

  localparam int         C_PAT_W  = 2 * MATRIX_DIM;
  localparam int         C_EVT_W  = 2 * COORD_W + 1;
  localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

  // ---------------------------------------------------------------- sampling
  logic [C_PAT_W-1:0] samp_q;

`ifdef BALL_READ_SYNC_EN
  logic [C_PAT_W-1:0] sync1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      samp_q  <= '0;
    end else begin
      sync1_q <= {Sx, Sy};
      samp_q  <= sync1_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_q <= '0;
    else        samp_q <= {Sx, Sy};
  end
`endif

  // ---------------------------------------------------------------- state
  qual_state_e        state_q, state_d;
  logic [C_PAT_W-1:0] cand_q, cand_d;
  logic [7:0]         count_q, count_d;
  logic [C_EVT_W-1:0] last_q, last_d;       // {on, x, y} last reported
  logic               last_vld_q, last_vld_d;
  logic [COORD_W-1:0] out_x_q, out_x_d;
  logic [COORD_W-1:0] out_y_q, out_y_d;
  logic               out_on_q, out_on_d;
  logic               out_valid_q, out_valid_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_overrun_q, err_overrun_d;

  logic               w_qualify;
  logic               w_legal;
  logic               w_on;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_emit;

  ball_decode u_decode (
    .i_sx    (cand_q[C_PAT_W-1:MATRIX_DIM]),
    .i_sy    (cand_q[MATRIX_DIM-1:0]),
    .o_legal (w_legal),
    .o_on    (w_on),
    .o_x     (w_x),
    .o_y     (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_TRACK;
      cand_q        <= '0;
      count_q       <= '0;
      last_q        <= '0;
      last_vld_q    <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_on_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      count_q       <= count_d;
      last_q        <= last_d;
      last_vld_q    <= last_vld_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_on_q      <= out_on_d;
      out_valid_q   <= out_valid_d;
      err_illegal_q <= err_illegal_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    count_d   = count_q;
    w_qualify = 1'b0;
    case (state_q)
      ST_TRACK: begin
        if (count_q == C_STABLE) begin
          // Candidate is stable: decide once. A sample that already moved
          // on starts a fresh track immediately instead of idling in WAIT.
          w_qualify = 1'b1;
          if (samp_q != cand_q) begin
            cand_d  = samp_q;
            count_d = 8'd1;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (samp_q != cand_q) begin
          cand_d  = samp_q;
          count_d = 8'd1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (samp_q != cand_q) begin
          state_d = ST_TRACK;
          cand_d  = samp_q;
          count_d = 8'd1;
        end
      end
      default: state_d = ST_TRACK;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_on_d    = out_on_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    last_vld_d  = last_vld_q;
    err_illegal_d = err_illegal_q;
    err_overrun_d = err_overrun_q;

    w_emit = w_qualify && w_legal && (!last_vld_q || ({w_on, w_x, w_y} != last_q));

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (w_emit) begin
      if (out_valid_q && !out_ready) begin
        // Pending event not taken: drop the new one, keep last-reported
        // so the dropped pattern can still be reported later.
        err_overrun_d = 1'b1;
      end else begin
        out_x_d     = w_x;
        out_y_d     = w_y;
        out_on_d    = w_on;
        out_valid_d = 1'b1;
        last_d      = {w_on, w_x, w_y};
        last_vld_d  = 1'b1;
      end
    end

    if (w_qualify && !w_legal) err_illegal_d = 1'b1;

    // Clear wins over a same-cycle set.
    if (err_clr) begin
      err_illegal_d = 1'b0;
      err_overrun_d = 1'b0;
    end
  end

  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_on      = out_on_q;
  assign out_valid   = out_valid_q;
  assign err_illegal = err_illegal_q;
  assign err_overrun = err_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_read.sv
// ============================================================================
// Module   : tb_ball_read
// Purpose  : Self-checking bench for ball_read (STABLE_CYCLES = 4).
//            Expected events are queued when stimulus is driven and
//            compared when the DUT hands an event over.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ball_read;

  localparam int S = 4;
`ifdef BALL_READ_SYNC_EN
  localparam int LAT = S + 3;
`else
  localparam int LAT = S + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] Sx = 8'h00;
  logic [7:0] Sy = 8'h00;
  logic [2:0] out_x;
  logic [2:0] out_y;
  logic       out_on;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       err_illegal;
  logic       err_overrun;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];   // {on, x, y}
  logic [6:0] e_mon;

  ball_read #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Sx          (Sx),
    .Sy          (Sy),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_on      (out_on),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_illegal (err_illegal),
    .err_overrun (err_overrun),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sx;
    logic [7:0] sy;
    logic       emit;
    logic       on;
    logic [2:0] x;
    logic [2:0] y;
    logic       illegal;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max, output int edges);
    edges = -1;
    for (int e = 1; e <= max; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  // Scoreboard: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_spurious: got on=%0d x=%0d y=%0d expected none",
                 out_on, out_x, out_y);
      end else begin
        e_mon = exp_q.pop_front();
        if ({out_on, out_x, out_y} != e_mon) begin
          n_fail++;
          $display("FAIL event_value: got on=%0d x=%0d y=%0d expected on=%0d x=%0d y=%0d",
                   out_on, out_x, out_y, e_mon[6], e_mon[5:3], e_mon[2:0]);
        end
      end
    end
  end

  initial begin
    int edges;

    //             sx     sy     emit  on    x     y     illegal
    vecs[0] = '{8'h01, 8'hFE, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0};
    vecs[1] = '{8'h80, 8'hFE, 1'b1, 1'b1, 3'd7, 3'd0, 1'b0};
    vecs[2] = '{8'h01, 8'h7F, 1'b1, 1'b1, 3'd0, 3'd7, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1};
    vecs[4] = '{8'h01, 8'h7F, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0}; // same as last reported
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[6] = '{8'h00, 8'hFE, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1};
    vecs[7] = '{8'h20, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1};
    vecs[8] = '{8'h20, 8'hFB, 1'b1, 1'b1, 3'd5, 3'd2, 1'b0};

    // Reset values appear without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid",   out_valid,   0);
    check("rst_x",       out_x,       0);
    check("rst_y",       out_y,       0);
    check("rst_on",      out_on,      0);
    check("rst_illegal", err_illegal, 0);
    check("rst_overrun", err_overrun, 0);
    step(2);
    rst_n = 1'b1;

    // Off pattern after reset is reported once; a 1-cycle glitch does not re-report it.
    exp_q.push_back(7'b0);
    wait_valid(20, edges);
    check("off_seen", (edges > 0) ? 1 : 0, 1);
    step(3);
    Sx = 8'h01; Sy = 8'hFE;
    step(1);
    Sx = 8'h00; Sy = 8'h00;
    step(12);
    check("off_glitch_novalid", out_valid, 0);

    // Latency from pin change to out_valid, one-cycle pulse with ready high.
    Sx = 8'h04; Sy = 8'hF7;
    exp_q.push_back({1'b1, 3'd2, 3'd3});
    wait_valid(20, edges);
    check("latency_edges", edges, LAT);
    step(1);
    check("pulse_one_cycle", out_valid, 0);
    step(4);

    // Table of patterns, each held long enough to qualify.
    for (int i = 0; i < 9; i++) begin
      Sx = vecs[i].sx;
      Sy = vecs[i].sy;
      if (vecs[i].emit) exp_q.push_back({vecs[i].on, vecs[i].x, vecs[i].y});
      step(S + 6);
      check($sformatf("vec%0d_illegal", i), err_illegal, vecs[i].illegal);
      check($sformatf("vec%0d_valid_idle", i), out_valid, 0);
      clr_pulse();
      check($sformatf("vec%0d_illegal_clr", i), err_illegal, 0);
    end

    // Glitch: 3 samples of one pattern, then a new pattern held.
    Sx = 8'h10; Sy = 8'hBF;
    step(3);
    Sx = 8'h80; Sy = 8'h7F;
    exp_q.push_back({1'b1, 3'd7, 3'd7});
    step(S + 8);
    check("glitch_overrun", err_overrun, 0);

    // Overrun: A pending and not accepted, B qualifies and is dropped.
    out_ready = 1'b0;
    Sx = 8'h02; Sy = 8'hFD;
    exp_q.push_back({1'b1, 3'd1, 3'd1});
    step(S + 6);
    check("ovr_a_pending", out_valid, 1);
    Sx = 8'h40; Sy = 8'hDF;
    step(S + 6);
    check("ovr_x_hold", out_x, 1);
    check("ovr_y_hold", out_y, 1);
    check("ovr_flag", err_overrun, 1);
    out_ready = 1'b1;
    step(1);
    check("ovr_accepted", out_valid, 0);
    clr_pulse();
    check("ovr_clr", err_overrun, 0);

    // Illegal pattern: flag set, no event, cleared by err_clr.
    Sx = 8'h03; Sy = 8'hFE;
    step(S + 6);
    check("illegal_flag", err_illegal, 1);
    check("illegal_novalid", out_valid, 0);
    clr_pulse();
    check("illegal_clr", err_illegal, 0);

    // Reset while an event is pending, then the held pattern is reported again.
    out_ready = 1'b0;
    Sx = 8'h08; Sy = 8'hEF;
    exp_q.push_back({1'b1, 3'd3, 3'd4});
    wait_valid(20, edges);
    check("prerst_valid", (edges > 0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_on", out_on, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 3'd3, 3'd4});
    wait_valid(20, edges);
    check("postrst_seen", (edges > 0) ? 1 : 0, 1);
    step(5);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
